// File: rtl/sisc_fetch.sv
// SISC instruction fetch stage: PC/IR ownership, req/ack instruction memory access,
// branch/jump PC loads (immediate or deferred until the in-flight fetch completes).
module sisc_fetch #(
  parameter int              AW       = 16,
  parameter logic [AW-1:0]   PC_RESET = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          fetch_go,
  input  logic          br_load,
  input  logic          br_rel,
  input  logic [AW-1:0] br_target,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_ack,
  output logic          ir_valid,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic [3:0]    rd,
  output logic [15:0]   imm,
  output logic [AW-1:0] pc_out,
  output logic          busy,
  output logic          fault
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, FAULT} state_t;

  localparam int            CW      = 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] pend_tgt_q;
  logic          pend_vld_q;
  logic [31:0]   ir_q;
  logic [CW-1:0] cnt_q;
  logic          req_q;
  logic          ir_valid_q;
  logic          busy_q;
  logic          fault_q;

  logic [AW-1:0] pc_inc_d;
  logic [AW-1:0] tgt_idle_d;
  logic [AW-1:0] tgt_wait_d;
  logic [AW-1:0] pc_ack_d;

  // While a fetch is outstanding the PC has not yet advanced, so relative
  // targets use PC+1 as the base to match what they would see after the ack.
  assign pc_inc_d   = pc_q + AW'(1);
  assign tgt_idle_d = br_rel ? pc_q + br_target : br_target;
  assign tgt_wait_d = br_rel ? pc_inc_d + br_target : br_target;

  always_comb begin
    pc_ack_d = pc_inc_d;
    if (br_load)
      pc_ack_d = tgt_wait_d;
    else if (pend_vld_q)
      pc_ack_d = pend_tgt_q;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= IDLE;
      pc_q       <= PC_RESET;
      addr_q     <= '0;
      pend_tgt_q <= '0;
      pend_vld_q <= 1'b0;
      ir_q       <= '0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, HOLD: begin
          if (br_load)
            pc_q <= tgt_idle_d;
          if (fetch_go) begin
            state_q    <= WAIT;
            req_q      <= 1'b1;
            addr_q     <= br_load ? tgt_idle_d : pc_q;
            cnt_q      <= '0;
            ir_valid_q <= 1'b0;
            busy_q     <= 1'b1;
            pend_vld_q <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            state_q    <= HOLD;
            ir_q       <= imem_rdata;
            pc_q       <= pc_ack_d;
            req_q      <= 1'b0;
            ir_valid_q <= 1'b1;
            busy_q     <= 1'b0;
            pend_vld_q <= 1'b0;
          end else if (cnt_q == TO_LAST) begin
            state_q    <= FAULT;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b1;
            pend_vld_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (br_load) begin
              pend_vld_q <= 1'b1;
              pend_tgt_q <= tgt_wait_d;
            end
          end
        end
        default: begin
          // FAULT is terminal until reset.
          state_q <= FAULT;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir_valid  = ir_valid_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign pc_out    = pc_q;
  assign opcode    = ir_q[31:28];
  assign mm        = ir_q[27:24];
  assign rs        = ir_q[23:20];
  assign rt        = ir_q[19:16];
  assign rd        = ir_q[15:12];
  assign imm       = ir_q[15:0];

endmodule

// File: tb/tb_sisc_fetch.sv
// Bench for sisc_fetch: directed scenarios with literal expectations, then random
// traffic against a cycle-level behavioural model compared on every falling edge.
module tb_sisc_fetch;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        fetch_go;
  logic        br_load;
  logic        br_rel;
  logic [15:0] br_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        ir_valid;
  logic [3:0]  opcode, mm, rs, rt, rd;
  logic [15:0] imm;
  logic [15:0] pc_out;
  logic        busy;
  logic        fault;

  int checks = 0;
  int errors = 0;

  sisc_fetch #(.AW(16), .PC_RESET(16'h0000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_f(rst_f), .fetch_go(fetch_go), .br_load(br_load),
    .br_rel(br_rel), .br_target(br_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .ir_valid(ir_valid), .opcode(opcode), .mm(mm), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .pc_out(pc_out), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch unit must look like after each rising edge.
  logic [15:0] m_pc, m_addr, m_pt;
  logic [31:0] m_ir;
  logic        m_busy, m_valid, m_fault, m_pv;
  int          m_wait;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_f) begin
        m_pc = 16'h0000; m_addr = 16'h0000; m_ir = 32'h0; m_pt = 16'h0;
        m_busy = 1'b0; m_valid = 1'b0; m_fault = 1'b0; m_pv = 1'b0; m_wait = 0;
      end else if (m_fault) begin
        m_fault = 1'b1;
      end else if (m_busy) begin
        if (br_load) begin
          m_pv = 1'b1;
          m_pt = br_rel ? 16'(m_pc + 16'd1 + br_target) : br_target;
        end
        if (imem_ack) begin
          m_ir = imem_rdata;
          m_pc = m_pv ? m_pt : 16'(m_pc + 16'd1);
          m_pv = 1'b0; m_busy = 1'b0; m_valid = 1'b1;
        end else if (m_wait + 1 == TIMEOUT) begin
          m_busy = 1'b0; m_fault = 1'b1;
        end else begin
          m_wait++;
        end
      end else begin
        if (br_load) m_pc = br_rel ? 16'(m_pc + br_target) : br_target;
        if (fetch_go) begin
          m_addr = m_pc; m_busy = 1'b1; m_valid = 1'b0; m_wait = 0; m_pv = 1'b0;
        end
      end
      chk("m_imem_req",  32'(imem_req),  32'(m_busy));
      chk("m_imem_addr", 32'(imem_addr), 32'(m_addr));
      chk("m_ir_valid",  32'(ir_valid),  32'(m_valid));
      chk("m_busy",      32'(busy),      32'(m_busy));
      chk("m_fault",     32'(fault),     32'(m_fault));
      chk("m_pc_out",    32'(pc_out),    32'(m_pc));
      chk("m_opcode",    32'(opcode),    32'(m_ir[31:28]));
      chk("m_mm",        32'(mm),        32'(m_ir[27:24]));
      chk("m_rs",        32'(rs),        32'(m_ir[23:20]));
      chk("m_rt",        32'(rt),        32'(m_ir[19:16]));
      chk("m_rd",        32'(rd),        32'(m_ir[15:12]));
      chk("m_imm",       32'(imm),       32'(m_ir[15:0]));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_branch(input logic rel, input logic [15:0] t);
    br_load = 1'b1; br_rel = rel; br_target = t;
    step();
    br_load = 1'b0;
  endtask

  task automatic do_ack(input logic [31:0] w);
    imem_ack = 1'b1; imem_rdata = w;
    step();
    imem_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          resp_active;
    int          resp_cnt, resp_d;

    rst_f = 1'b0; fetch_go = 1'b0; br_load = 1'b0; br_rel = 1'b0;
    br_target = 16'h0; imem_rdata = 32'h0; imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_valid", 32'(ir_valid), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    rst_f = 1'b1;

    // Basic fetch, ack three cycles after request.
    fetch_go = 1'b1; step(); fetch_go = 1'b0;
    chk("f1_req", 32'(imem_req), 32'h1);
    chk("f1_addr", 32'(imem_addr), 32'h0);
    chk("f1_busy", 32'(busy), 32'h1);
    step(); step();
    do_ack(32'h2110_0005);
    chk("f1_valid", 32'(ir_valid), 32'h1);
    chk("f1_opcode", 32'(opcode), 32'h2);
    chk("f1_mm", 32'(mm), 32'h1);
    chk("f1_rs", 32'(rs), 32'h1);
    chk("f1_imm", 32'(imm), 32'h5);
    chk("f1_pc", 32'(pc_out), 32'h1);
    chk("f1_req_low", 32'(imem_req), 32'h0);

    // Absolute branch then fetch from the target with minimum latency.
    do_branch(1'b0, 16'h0004);
    chk("abs_pc4", 32'(pc_out), 32'h4);
    do_branch(1'b0, 16'h0020);
    chk("abs_pc20", 32'(pc_out), 32'h20);
    fetch_go = 1'b1; step(); fetch_go = 1'b0;
    chk("abs_addr", 32'(imem_addr), 32'h20);
    do_ack(32'hA000_0000);
    chk("abs_pc21", 32'(pc_out), 32'h21);
    chk("abs_opcode", 32'(opcode), 32'hA);

    // Relative branches with wrap in both directions.
    do_branch(1'b0, 16'hFFFF);
    do_branch(1'b1, 16'h0001);
    chk("rel_wrap0", 32'(pc_out), 32'h0);
    do_branch(1'b0, 16'd10);
    do_branch(1'b1, 16'hFFFE);
    chk("rel_neg", 32'(pc_out), 32'h8);

    // Branch while a fetch is outstanding takes effect at the ack.
    do_branch(1'b0, 16'd5);
    fetch_go = 1'b1; step(); fetch_go = 1'b0;
    chk("wb_addr", 32'(imem_addr), 32'h5);
    step();
    do_branch(1'b0, 16'h0040);
    chk("wb_pc_held", 32'(pc_out), 32'h5);
    step();
    do_ack(32'h3456_789A);
    chk("wb_pc", 32'(pc_out), 32'h40);
    chk("wb_opcode", 32'(opcode), 32'h3);
    chk("wb_imm", 32'(imm), 32'h789A);

    // Branch and fetch in the same cycle fetch from the new target.
    br_load = 1'b1; br_rel = 1'b0; br_target = 16'h0100; fetch_go = 1'b1;
    step();
    br_load = 1'b0; fetch_go = 1'b0;
    chk("bg_addr", 32'(imem_addr), 32'h100);
    chk("bg_pc", 32'(pc_out), 32'h100);
    do_ack(32'h1000_0000);
    chk("bg_pc_ack", 32'(pc_out), 32'h101);

    // Relative branch while waiting uses PC+1 as its base.
    fetch_go = 1'b1; step(); fetch_go = 1'b0;
    do_branch(1'b1, 16'h0002);
    do_ack(32'h5000_0001);
    chk("wr_pc", 32'(pc_out), 32'h104);

    // Timeout: request stays up for TIMEOUT cycles, then a sticky fault.
    fetch_go = 1'b1; step(); fetch_go = 1'b0;
    repeat (TIMEOUT - 1) step();
    chk("to_req_still", 32'(imem_req), 32'h1);
    chk("to_fault_not", 32'(fault), 32'h0);
    step();
    chk("to_req_low", 32'(imem_req), 32'h0);
    chk("to_fault", 32'(fault), 32'h1);
    fetch_go = 1'b1; step(); fetch_go = 1'b0;
    do_ack(32'hFFFF_FFFF);
    do_branch(1'b0, 16'h0077);
    chk("to_stuck_fault", 32'(fault), 32'h1);
    chk("to_stuck_req", 32'(imem_req), 32'h0);
    chk("to_stuck_pc", 32'(pc_out), 32'h104);
    chk("to_stuck_op", 32'(opcode), 32'h5);
    rst_f = 1'b0; step();
    chk("to_rst_fault", 32'(fault), 32'h0);
    rst_f = 1'b1;

    // Reset while a fetch is outstanding abandons it.
    do_branch(1'b0, 16'h0007);
    fetch_go = 1'b1; step(); fetch_go = 1'b0;
    step(); step();
    rst_f = 1'b0; #1;
    chk("rw_req", 32'(imem_req), 32'h0);
    chk("rw_pc", 32'(pc_out), 32'h0);
    chk("rw_valid", 32'(ir_valid), 32'h0);
    step();
    rst_f = 1'b1;
    do_ack(32'hF123_4567);
    chk("rw_late_op", 32'(opcode), 32'h0);
    chk("rw_late_valid", 32'(ir_valid), 32'h0);
    chk("rw_late_pc", 32'(pc_out), 32'h0);

    // Random traffic with a responsive memory that occasionally stalls out.
    resp_active = 1'b0; resp_cnt = 0; resp_d = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      if (!rst_f) rst_f = 1'b1;
      else if ($urandom_range(0, 249) == 0) rst_f = 1'b0;
      imem_ack = 1'b0;
      if (imem_req) begin
        if (!resp_active) begin
          resp_active = 1'b1;
          resp_cnt = 0;
          resp_d = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(1, 5));
        end
        resp_cnt++;
        if (resp_cnt == resp_d) begin
          imem_ack = 1'b1;
          imem_rdata = $urandom;
        end
      end else begin
        resp_active = 1'b0;
      end
      fetch_go  = ($urandom_range(0, 9) < 3);
      br_load   = ($urandom_range(0, 9) == 0);
      br_rel    = 1'($urandom_range(0, 1));
      br_target = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8)) - 16'd4;
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
